class_search_ctrl: RTL and testbench
====================================

Name: class_search_ctrl

Overview:
- Sequences the class hypervector ROM (`class_vec_gen`) frame by frame to run an associative search.
- For each class it computes the Hamming distance between a frame-partitioned query hypervector and the class vector, then reports the closest class.
- Sits between the query encoder/buffer and the classification result consumer.
- Owns the ROM's `frame_id` / `frame_index` address lines.

Parameters:
- N_CLASSES, 8: number of classes, which equals the number of ROM frame_id values.
- N_FRAMES, 3: frames per hypervector, which equals the number of ROM frame_index values.
- FRAME_W, 64: bits per frame.
- ID_W, 3: width of frame_id / class index, clog2(N_CLASSES).
- FIDX_W, 2: width of frame_index, clog2(N_FRAMES).
- DIST_W, 8: distance width, clog2(N_FRAMES*FRAME_W+1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a search; sampled only in IDLE.
- busy  out  1  high in SCAN and DRAIN.
- frame_id  out  ID_W  ROM class address.
- frame_index  out  FIDX_W  ROM frame address; also used as the query buffer frame address.
- class_vec_in  in  FRAME_W  ROM data, combinational from frame_id/frame_index.
- query_frame  in  FRAME_W  query frame selected by frame_index, combinational, same cycle.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- best_class  out  ID_W  index of the nearest class.
- best_dist  out  DIST_W  its total Hamming distance.

Behaviour:
- Reset values:
  - State is IDLE.
  - busy=0, res_valid=0.
  - frame_id=0, frame_index=0.
  - best_class=0, best_dist=all ones.
  - Internal accumulator, pipeline valid bits and counters are 0.
- FSM state IDLE: if start=1, go to SCAN. Class counter c=0 and frame counter f=0.
- FSM state SCAN:
  - Each cycle drive frame_id=c and frame_index=f.
  - f increments; on f=N_FRAMES-1, f wraps to 0 and c increments.
  - After issuing (N_CLASSES-1, N_FRAMES-1), go to DRAIN.
  - Exactly N_CLASSES*N_FRAMES issue cycles; f is the inner loop.
- FSM state DRAIN: one cycle, then go to DONE.
- FSM state DONE: res_valid=1. When res_ready=1, go to IDLE. start is ignored in DONE.
- Addresses are 0 outside SCAN.
- Pipeline stage 1 (registered at the end of each issue cycle):
  - pd = popcount(query_frame XOR class_vec_in), zero-extended to DIST_W.
  - Also register p_valid, p_last (f==N_FRAMES-1), p_first (f==0) and p_class=c.
- Pipeline stage 2 (cycle after stage 1):
  - If p_valid, sum = (p_first ? 0 : acc) + pd.
  - If p_last, compare sum against best_dist.
  - If sum < best_dist (strict), set best_dist=sum and best_class=p_class. Ties keep the lower class index.
  - Otherwise acc=sum.
- Sums never exceed N_FRAMES*FRAME_W, so there is no saturation or overflow.
- On entry to SCAN: best_dist is set to all ones and best_class to 0.
- Latency: start accepted in cycle T.
  - Issues occur in T+1..T+N_CLASSES*N_FRAMES.
  - DRAIN is at T+N_CLASSES*N_FRAMES+1.
  - res_valid rises at T+N_CLASSES*N_FRAMES+2, which is T+26 with the defaults.
- Result stability: best_class and best_dist are held stable from res_valid rising until the handshake completes.
- Stability requirement on the query source: query_frame must be stable for the addressed frame throughout SCAN. The controller does not latch the query.
- start while busy or in DONE: ignored, not queued.
- Back-to-back searches:
  - The handshake in DONE returns to IDLE next cycle.
  - The earliest next accept is the following cycle, giving 1 idle cycle minimum between searches.
- Reset mid-operation: rst in any state returns all state and outputs to reset values next edge. The partial search is discarded and no res_valid is produced.
- Constraint: N_CLASSES and N_FRAMES must each be ≥1. Counters compare against N-1, not 2^W-1, so non-power-of-two counts wrap correctly.

Test Plan:
- Query equal to class 2 frames 0..2, start pulse at T → frame addresses sweep (0,0),(0,1),(0,2),(1,0)…(7,2) in T+1..T+24; res_valid at T+26 with best_class=2, best_dist=0.
- Query equal to class 5 with 3 bits flipped in frame 1 → best_class=5, best_dist=3; busy high T+1..T+25 and low at T+26.
- Tie: ROM model with classes 3 and 6 identical and the query matching both → best_class=3.
- Query all zeros against a ROM model where class 0 is all ones and every other class has exactly 100 ones → best_class=1, best_dist=100. Class 0's total of 192 is computed without overflow.
- Backpressure: res_ready low for 10 cycles after res_valid, with start pulsed during that window → outputs stable, no new search starts. res_ready=1 → IDLE next cycle; start the following cycle is accepted.
- rst asserted at T+10 mid-SCAN → next cycle busy=0, res_valid=0, addresses 0, best_dist=255. A new start yields a correct result 26 cycles later.

Source files
------------

// File: rtl/class_search_ctrl.sv
// Associative-search sequencer: walks the class hypervector ROM frame by frame,
// accumulates per-class Hamming distance against the query and reports the nearest class.
module class_search_ctrl #(
  parameter int N_CLASSES = 8,
  parameter int N_FRAMES  = 3,
  parameter int FRAME_W   = 64,
  parameter int ID_W      = 3,
  parameter int FIDX_W    = 2,
  parameter int DIST_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic [ID_W-1:0]    frame_id,
  output logic [FIDX_W-1:0]  frame_index,
  input  logic [FRAME_W-1:0] class_vec_in,
  input  logic [FRAME_W-1:0] query_frame,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ID_W-1:0]    best_class,
  output logic [DIST_W-1:0]  best_dist
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ID_W-1:0]   C_LAST = ID_W'(N_CLASSES - 1);
  localparam logic [FIDX_W-1:0] F_LAST = FIDX_W'(N_FRAMES - 1);

  state_t r_state;
  state_t w_next;
  logic   w_accept;

  logic [ID_W-1:0]   r_c;
  logic [FIDX_W-1:0] r_f;
  logic              w_last_f;
  logic              w_last_issue;

  logic [FRAME_W-1:0] w_diff;
  logic [DIST_W-1:0]  w_pd;

  logic              r_p_valid;
  logic              r_p_last;
  logic              r_p_first;
  logic [ID_W-1:0]   r_p_class;
  logic [DIST_W-1:0] r_pd;

  logic [DIST_W-1:0] r_acc;
  logic [DIST_W-1:0] w_sum;
  logic [ID_W-1:0]   r_best_class;
  logic [DIST_W-1:0] r_best_dist;

  assign w_last_f     = (r_f == F_LAST);
  assign w_last_issue = w_last_f && (r_c == C_LAST);

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    busy        = 1'b0;
    res_valid   = 1'b0;
    frame_id    = '0;
    frame_index = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next   = S_SCAN;
          w_accept = 1'b1;
        end
      end
      S_SCAN: begin
        busy        = 1'b1;
        frame_id    = r_c;
        frame_index = r_f;
        if (w_last_issue) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Frame index is the inner loop; counters compare against N-1 so odd counts wrap correctly.
  always_ff @(posedge clk) begin
    if (rst || r_state != S_SCAN) begin
      r_c <= '0;
      r_f <= '0;
    end else if (w_last_f) begin
      r_f <= '0;
      r_c <= r_c + 1'b1;
    end else begin
      r_f <= r_f + 1'b1;
    end
  end

  assign w_diff = query_frame ^ class_vec_in;

  always_comb begin
    w_pd = '0;
    for (int i = 0; i < FRAME_W; i++) w_pd = w_pd + DIST_W'(w_diff[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_valid <= 1'b0;
      r_p_last  <= 1'b0;
      r_p_first <= 1'b0;
      r_p_class <= '0;
      r_pd      <= '0;
    end else begin
      r_p_valid <= (r_state == S_SCAN);
      r_p_last  <= w_last_f;
      r_p_first <= (r_f == '0);
      r_p_class <= r_c;
      r_pd      <= w_pd;
    end
  end

  assign w_sum = (r_p_first ? '0 : r_acc) + r_pd;

  // Strict less-than keeps the lower class index on ties.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc        <= '0;
      r_best_class <= '0;
      r_best_dist  <= '1;
    end else if (w_accept) begin
      r_best_class <= '0;
      r_best_dist  <= '1;
    end else if (r_p_valid) begin
      if (r_p_last) begin
        if (w_sum < r_best_dist) begin
          r_best_dist  <= w_sum;
          r_best_class <= r_p_class;
        end
      end else begin
        r_acc <= w_sum;
      end
    end
  end

  assign best_class = r_best_class;
  assign best_dist  = r_best_dist;

endmodule

// File: tb/tb_class_search_ctrl.sv
// Directed bench for class_search_ctrl: behavioural ROM/query buffer and hand-derived results.
module tb_class_search_ctrl;

  localparam int NC = 8;
  localparam int NF = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        res_ready;
  logic        busy;
  logic        res_valid;
  logic [2:0]  frame_id;
  logic [1:0]  frame_index;
  logic [63:0] class_vec_in;
  logic [63:0] query_frame;
  logic [2:0]  best_class;
  logic [7:0]  best_dist;

  logic [63:0] rom [NC*NF];
  logic [63:0] qry [NF];

  int checks   = 0;
  int failures = 0;

  class_search_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .frame_id     (frame_id),
    .frame_index  (frame_index),
    .class_vec_in (class_vec_in),
    .query_frame  (query_frame),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .best_class   (best_class),
    .best_dist    (best_dist)
  );

  always #5 clk = ~clk;

  always_comb begin
    int idx;
    idx = int'(frame_id) * NF + int'(frame_index);
    class_vec_in = (idx < NC*NF) ? rom[idx] : 64'd0;
    query_frame  = (int'(frame_index) < NF) ? qry[frame_index] : 64'd0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mix(input int i);
    logic [63:0] x;
    x = 64'(i + 1) * 64'h9E3779B97F4A7C15;
    x = x ^ (x >> 30);
    x = x * 64'hBF58476D1CE4E5B9;
    x = x ^ (x >> 27);
    x = x * 64'h94D049BB133111EB;
    x = x ^ (x >> 31);
    return x;
  endfunction

  task automatic load_random_rom();
    for (int i = 0; i < NC*NF; i++) rom[i] = mix(i);
  endtask

  task automatic query_from_class(input int c);
    for (int f = 0; f < NF; f++) qry[f] = rom[c*NF + f];
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge of cycle T+26 (DONE).
  task automatic run_search(input string tag, input logic [2:0] exp_cls,
                            input logic [7:0] exp_dist, input bit chk_addr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ":dist_cleared"}, 64'(best_dist), 64'd255);
    for (int k = 0; k < NC*NF; k++) begin
      if (k > 0) @(negedge clk);
      if (chk_addr) begin
        check($sformatf("%s:id%0d", tag, k), 64'(frame_id), 64'(k / NF));
        check($sformatf("%s:idx%0d", tag, k), 64'(frame_index), 64'(k % NF));
        check($sformatf("%s:busy%0d", tag, k), 64'(busy), 64'd1);
      end
    end
    @(negedge clk);
    check({tag, ":drain_busy"}, 64'(busy), 64'd1);
    check({tag, ":drain_valid"}, 64'(res_valid), 64'd0);
    check({tag, ":drain_id"}, 64'(frame_id), 64'd0);
    @(negedge clk);
    check({tag, ":valid"}, 64'(res_valid), 64'd1);
    check({tag, ":busy_low"}, 64'(busy), 64'd0);
    check({tag, ":class"}, 64'(best_class), 64'(exp_cls));
    check({tag, ":dist"}, 64'(best_dist), 64'(exp_dist));
  endtask

  task automatic handshake(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, ":idle_valid"}, 64'(res_valid), 64'd0);
    check({tag, ":idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] held_cls;
    logic [7:0] held_dist;
    rst       = 1'b1;
    start     = 1'b0;
    res_ready = 1'b0;
    load_random_rom();
    for (int f = 0; f < NF; f++) qry[f] = 64'd0;
    repeat (3) @(negedge clk);
    check("rst:busy", 64'(busy), 64'd0);
    check("rst:valid", 64'(res_valid), 64'd0);
    check("rst:id", 64'(frame_id), 64'd0);
    check("rst:idx", 64'(frame_index), 64'd0);
    check("rst:class", 64'(best_class), 64'd0);
    check("rst:dist", 64'(best_dist), 64'd255);
    rst = 1'b0;
    @(negedge clk);

    // Exact match with class 2, with full address sweep.
    query_from_class(2);
    run_search("exact2", 3'd2, 8'd0, 1'b1);
    handshake("exact2");

    // Class 5 with three bits flipped in frame 1; issued back-to-back after the handshake.
    query_from_class(5);
    qry[1] = qry[1] ^ 64'h0000_0100_0001_0001;
    run_search("flip5", 3'd5, 8'd3, 1'b0);
    handshake("flip5");

    // Classes 3 and 6 identical: lower index wins the tie.
    load_random_rom();
    for (int f = 0; f < NF; f++) rom[6*NF + f] = rom[3*NF + f];
    query_from_class(3);
    @(negedge clk);
    run_search("tie", 3'd3, 8'd0, 1'b0);
    handshake("tie");

    // Zero query: class 0 totals 192, the rest 100 each.
    for (int c = 0; c < NC; c++) begin
      if (c == 0) begin
        for (int f = 0; f < NF; f++) rom[f] = '1;
      end else begin
        rom[c*NF + 0] = '1;
        rom[c*NF + 1] = (64'd1 << 36) - 64'd1;
        rom[c*NF + 2] = 64'd0;
      end
    end
    for (int f = 0; f < NF; f++) qry[f] = 64'd0;
    @(negedge clk);
    run_search("zeroq", 3'd1, 8'd100, 1'b0);

    // Backpressure with a start pulse that must be ignored.
    held_cls  = 3'd1;
    held_dist = 8'd100;
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      @(negedge clk);
      check($sformatf("bp:valid%0d", i), 64'(res_valid), 64'd1);
      check($sformatf("bp:busy%0d", i), 64'(busy), 64'd0);
      check($sformatf("bp:class%0d", i), 64'(best_class), 64'(held_cls));
      check($sformatf("bp:dist%0d", i), 64'(best_dist), 64'(held_dist));
    end
    start = 1'b0;
    handshake("bp");
    load_random_rom();
    query_from_class(7);
    run_search("b2b", 3'd7, 8'd0, 1'b0);
    handshake("b2b");

    // Reset in cycle T+10 of a scan.
    query_from_class(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst:busy", 64'(busy), 64'd0);
    check("midrst:valid", 64'(res_valid), 64'd0);
    check("midrst:id", 64'(frame_id), 64'd0);
    check("midrst:idx", 64'(frame_index), 64'd0);
    check("midrst:dist", 64'(best_dist), 64'd255);
    check("midrst:class", 64'(best_class), 64'd0);
    repeat (30) @(negedge clk);
    check("midrst:no_valid", 64'(res_valid), 64'd0);
    query_from_class(6);
    qry[2] = qry[2] ^ 64'h8000_0000_0000_0001;
    run_search("postrst", 3'd6, 8'd2, 1'b0);
    handshake("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
